// File: rtl/data_sram_responder.sv
// Word-addressed data SRAM behind the CPU data_sram_* bus: byte-enabled writes,
// registered reads, and WAIT_CYCLES stall cycles inserted in front of every access.
module data_sram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rdata;
  logic              w_acc_en;
  logic [3:0]        w_acc_wen;
  logic [ADDR_W-1:0] w_acc_idx;
  logic [31:0]       w_acc_wdata;
  logic              w_stall;
  logic              w_unused;

  // Byte offset and bits above the array aliasing range are deliberately dropped.
  assign w_unused = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  generate
    if (WAIT_CYCLES == 0) begin : g_nowait
      assign w_acc_en    = data_sram_en;
      assign w_acc_wen   = data_sram_wen;
      assign w_acc_idx   = data_sram_addr[ADDR_W+1:2];
      assign w_acc_wdata = data_sram_wdata;
      assign w_stall     = 1'b0;
    end else begin : g_wait
      localparam logic       ST_IDLE  = 1'b0;
      localparam logic       ST_WAIT  = 1'b1;
      localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

      logic              r_state;
      logic              w_state_next;
      logic [3:0]        r_cnt;
      logic [3:0]        r_wen;
      logic [ADDR_W-1:0] r_idx;
      logic [31:0]       r_wdata;

      // The request is latched on acceptance; bus activity during WAIT is ignored.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_wen   <= '0;
          r_idx   <= '0;
          r_wdata <= '0;
        end else begin
          r_state <= w_state_next;
          if (r_state == ST_IDLE && data_sram_en) begin
            r_cnt   <= CNT_INIT;
            r_wen   <= data_sram_wen;
            r_idx   <= data_sram_addr[ADDR_W+1:2];
            r_wdata <= data_sram_wdata;
          end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
      end

      always_comb begin
        w_state_next = r_state;
        case (r_state)
          ST_IDLE: if (data_sram_en) w_state_next = ST_WAIT;
          ST_WAIT: if (r_cnt == 4'd0) w_state_next = ST_IDLE;
          default: w_state_next = ST_IDLE;
        endcase
      end

      always_comb begin
        w_stall  = 1'b0;
        w_acc_en = 1'b0;
        case (r_state)
          ST_IDLE: w_stall = data_sram_en;
          ST_WAIT: begin
            w_stall  = (r_cnt != 4'd0);
            w_acc_en = (r_cnt == 4'd0);
          end
          default: ;
        endcase
      end

      assign w_acc_wen   = r_wen;
      assign w_acc_idx   = r_idx;
      assign w_acc_wdata = r_wdata;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_acc_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_wen[b]) r_mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= '0;
    end else if (w_acc_en && w_acc_wen == 4'b0000) begin
      r_rdata <= r_mem[w_acc_idx];
    end
  end

  assign data_sram_rdata = r_rdata;
  // Stall is released as soon as reset asserts, even with en still high.
  assign stallreq        = w_stall & resetn;

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- CPU-facing responder for the data SRAM interface.
- Sits on the far side of the data_sram_en/wen/addr/wdata/rdata port driven by the pipeline's execute/DC stages; the MEM stage consumes its data_sram_rdata.
- Holds a word-addressed on-chip array, applies byte-enabled writes and returns registered read data.
- Inserts a configurable number of wait states via stallreq so the pipeline sees realistic memory latency.

Parameters:
- ADDR_W, 10, word-index bits; array depth = 2^ADDR_W words of 32 bits.
- WAIT_CYCLES, 0, stall cycles per access; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- data_sram_en  in  1  access request. Held stable by the CPU while stallreq=1.
- data_sram_wen  in  4  byte write enables; wen[i] selects wdata[8i+7:8i]. 0000 means read.
- data_sram_addr  in  32  byte address; word index = addr[ADDR_W+1:2].
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  registered read data.
- stallreq  out  1  pipeline stall request; combinational from state and inputs.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, cnt=0, data_sram_rdata=0, stallreq=0.
  - Array contents are not reset.
  - Any pending captured request is discarded; a pending write is never performed.
- Address decode:
  - addr[1:0] is ignored.
  - Bits above ADDR_W+1 are ignored, so addresses alias modulo 4*2^ADDR_W.
- Access operation, always applied to the captured (or, for WAIT_CYCLES=0, live) request on one rising edge:
  - Write (wen!=0): for each i with wen[i]=1, byte i of the array word is replaced by wdata byte i; other bytes are kept. data_sram_rdata is unchanged.
  - Read (wen=0): data_sram_rdata <= array word. Valid from the cycle after the access edge and held until the next read.
  - Read-after-write to the same word in consecutive accesses returns the new data; the array is written before the later read edge.
- WAIT_CYCLES=0:
  - No FSM traversal; stallreq is constantly 0.
  - Every cycle with en=1 is a distinct access, performed at the end of that cycle.
  - Read latency is 1 cycle. Back-to-back accesses sustain one per cycle.
- WAIT_CYCLES=W>0, states IDLE and WAIT:
  - IDLE, en=0: stay; stallreq=0.
  - IDLE, en=1: stallreq=1 combinationally. At the edge, capture wen/addr/wdata, cnt<=W-1, go to WAIT.
  - WAIT, cnt!=0: stallreq=1, cnt<=cnt-1; live inputs are ignored.
  - WAIT, cnt==0: stallreq=0. At the edge, perform the access with the captured request and go to IDLE.
  - The request still presented on the bus during this cycle is the same instruction and is not re-accepted.
  - Net result: exactly W stall cycles per access; read data is valid on the cycle after stallreq falls.
  - IDLE with en=1 on the cycle right after returning from WAIT is a new request and is accepted normally.
- wen changing while stallreq=1 violates the protocol. The captured value is used.

Test Plan:
- W=0: write wen=1111, wdata=0x12345678, addr=0x10, then read addr=0x10 -> next cycle rdata=0x12345678; stallreq stays 0.
- W=0: after the above, write wen=0010, wdata=0x0000AB00 to 0x10, then read 0x13 -> rdata=0x1234AB78 (addr[1:0] ignored).
- W=3: read of a word holding 0xDEADBEEF -> stallreq=1 on cycles 0,1,2 and 0 on cycle 3; rdata=0xDEADBEEF from cycle 4; rdata unchanged before that.
- W=2: write 0xCAFEF00D at 0x0, then read at 0x0 + 4*2^ADDR_W (alias) -> rdata=0xCAFEF00D; each access stalls exactly 2 cycles; the write leaves the prior rdata untouched.
- W=3: accept a write wen=1111 to 0x20, then drop resetn during the WAIT cnt=1 cycle -> stallreq=0 and rdata=0 immediately; a later read of 0x20 returns the pre-write value.
- W=1: back-to-back reads of 0x4 and 0x8 (en held high) -> stall pattern 1,0,1,0; rdata shows word[1] then word[2], each valid one cycle after its stallreq low cycle.
